uart_tx_dual: RTL and testbench
===============================

// Module: uart_tx_dual
// PURPOSE
//  Dual-rate UART transmitter, the transmit side of the board serial link.
//  Serialises command bytes at the fast command rate and picture bytes at the slow picture rate onto one tx line.
//  A mode input selects the active source, using the same command/picture split as the receive path.
//  Frame format: 8N1 (or 8N2), LSB first, line idle high.
// PARAMETERS
//  CMD_CLKS_PER_BIT   52     clock_system cycles per bit, command mode (mode=0)
//  PIC_CLKS_PER_BIT   1250   clock_system cycles per bit, picture mode (mode=1)
//  STOP_BITS          1      number of stop bits; legal values 1 or 2
// PORTS
//  clock_system  in   1  system clock
//  rstn          in   1  asynchronous, active-low reset
//  mode          in   1  0 = command source/rate, 1 = picture source/rate
//  cmd_valid     in   1  cmd_data valid; hold until accepted
//  cmd_data      in   8  command byte
//  cmd_ready     out  1  command byte accepted when cmd_valid & cmd_ready
//  pic_valid     in   1  pic_data valid; hold until accepted
//  pic_data      in   8  picture byte
//  pic_ready     out  1  picture byte accepted when pic_valid & pic_ready
//  tx            out  1  serial output, registered
//  busy          out  1  high while a frame is in progress (state != IDLE)
//  tx_done       out  1  one-cycle pulse at end of last stop bit
//  frame_mode    out  1  mode latched for the current or most recent frame
// BEHAVIOUR
//  Reset (async, immediate): tx=1, busy=0, tx_done=0, frame_mode=0, state=IDLE, counters=0. Resets mid-frame too.
//  Ready signals are combinational:
//   cmd_ready = (state==IDLE) & ~mode
//   pic_ready = (state==IDLE) &  mode
//  An unselected source is never accepted; its valid is ignored and it waits.
//  Accept at edge k: data goes into shift reg, mode goes into frame_mode, N = CLKS_PER_BIT of frame_mode.
//   Same edge: state<=START, tx<=0, bit_cnt<=0, baud_cnt<=0.
//  FSM IDLE -> START -> DATA -> STOP -> IDLE. baud_cnt is 16-bit and counts 0..N-1 in each bit period.
//  START: tx=0 for exactly N cycles. At baud_cnt==N-1: go to DATA, tx<=d[0].
//  DATA: each bit lasts N cycles, LSB first.
//   At baud_cnt==N-1 with bit_cnt<7: bit_cnt++, tx<=next bit.
//   At bit_cnt==7: go to STOP, tx<=1.
//  STOP: tx=1 for STOP_BITS*N cycles. At the final count: state<=IDLE, tx_done<=1 for 1 cycle.
//  Latency: accept edge to first tx falling edge = 0 cycles (tx low from edge k).
//   Frame length is (9+STOP_BITS)*N cycles.
//  Back-to-back: IDLE lasts at least 1 cycle, so the minimum frame period is (9+STOP_BITS)*N+1 cycles.
//  mode changes during a frame have no effect until the next IDLE; frame_mode and N are fixed per frame.
//  Input data is ignored after acceptance; the source may change cmd_data/pic_data freely.
//  busy = (state!=IDLE). tx_done and ready are never high in the same cycle as busy.
//  Both valids high in IDLE: only the source selected by mode is accepted.
// TESTING
//  1. mode=0, cmd 0x55 -> tx: 0 for 52 cycles, then 1,0,1,0,1,0,1,0 at 52 cycles each, then 1.
//     tx_done fires 520 cycles after accept.
//  2. mode=1, pic 0xA3 -> bits 1,1,0,0,0,1,0,1 at 1250 cycles each; tx_done at cycle 12500; busy high throughout.
//  3. mode=0 with pic_valid=1 held -> pic_ready stays 0, tx stays 1.
//     Switch mode=1 -> accepted in the next cycle.
//  4. Accept cmd, toggle mode to 1 at cycle 100 -> frame still 520 cycles at 52/bit, frame_mode=0.
//     Next frame uses 1250/bit.
//  5. cmd_valid held with 0x00 then 0xFF -> second start bit begins 521 cycles after the first;
//     frames decode correctly.
//  6. rstn low at cycle 300 of a cmd frame -> tx=1 and busy=0 immediately, no tx_done.
//     After release, a new frame starts cleanly.

Source files
------------

// File: rtl/uart_tx_dual.sv
// Dual-rate 8N1/8N2 UART transmitter for the board serial link.
// Command bytes go out at the fast command rate, picture bytes at the slow
// picture rate; the mode input picks which source may start the next frame.
// Rate and source are latched at accept and held for the whole frame.
module uart_tx_dual #(
    parameter int unsigned CMD_CLKS_PER_BIT = 52,
    parameter int unsigned PIC_CLKS_PER_BIT = 1250,
    parameter int unsigned STOP_BITS        = 1
) (
    input  logic       clock_system,
    input  logic       rstn,
    input  logic       mode,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic       pic_valid,
    input  logic [7:0] pic_data,
    output logic       pic_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output logic       frame_mode
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DATA_W = 8;

    // Last baud count of one bit period, and of the whole stop period
    localparam logic [CNT_W-1:0] CMD_BIT_LAST  = CNT_W'(CMD_CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PIC_BIT_LAST  = CNT_W'(PIC_CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CMD_STOP_LAST = CNT_W'(STOP_BITS * CMD_CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PIC_STOP_LAST = CNT_W'(STOP_BITS * PIC_CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;
    logic                fmode_q, fmode_d;

    logic                idle_c;
    logic                accept_c;
    logic                bit_end_c;
    logic                stop_end_c;
    logic [CNT_W-1:0]    bit_last_c;
    logic [CNT_W-1:0]    stop_last_c;

    // Handshake and bit-period boundaries for the rate latched with the frame
    always_comb begin
        idle_c      = (state_q == S_IDLE);
        cmd_ready   = idle_c & ~mode;
        pic_ready   = idle_c & mode;
        accept_c    = (cmd_ready & cmd_valid) | (pic_ready & pic_valid);
        bit_last_c  = fmode_q ? PIC_BIT_LAST : CMD_BIT_LAST;
        stop_last_c = fmode_q ? PIC_STOP_LAST : CMD_STOP_LAST;
        bit_end_c   = (baud_cnt_q == bit_last_c);
        stop_end_c  = (baud_cnt_q == stop_last_c);
    end

    // Frame sequencing: next state, counters and next tx level
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + CNT_W'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        fmode_d    = fmode_q;

        case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                tx_d       = 1'b1;
                if (accept_c) begin
                    state_d   = S_START;
                    tx_d      = 1'b0;
                    bit_cnt_d = '0;
                    shift_d   = mode ? pic_data : cmd_data;
                    fmode_d   = mode;
                end
            end
            S_START: begin
                if (bit_end_c) begin
                    state_d    = S_DATA;
                    baud_cnt_d = '0;
                    tx_d       = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        tx_d      = shift_q[bit_cnt_d];
                    end
                end
            end
            S_STOP: begin
                // Stop period is counted as one run of STOP_BITS bit times
                if (stop_end_c) begin
                    state_d    = S_IDLE;
                    baud_cnt_d = '0;
                    done_d     = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                baud_cnt_d = '0;
                tx_d       = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops any frame in flight
    always_ff @(posedge clock_system or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            fmode_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            fmode_q    <= fmode_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign tx_done    = done_q;
    assign frame_mode = fmode_q;

endmodule

// File: tb/tb_uart_tx_dual.sv
// Bench for uart_tx_dual: a frame-level model (accept time, rate, byte)
// predicts tx/busy/tx_done/frame_mode/ready on every cycle, and directed
// scenarios pin bit values and frame timing with literal expectations.
module tb_uart_tx_dual;

    localparam int N_CMD = 52;
    localparam int N_PIC = 1250;
    localparam int SB    = 1;

    logic       clk = 1'b0;
    logic       rstn;
    logic       mode = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       pic_valid = 1'b0;
    logic [7:0] pic_data = 8'h00;
    logic       cmd_ready, pic_ready, tx, busy, tx_done, frame_mode;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_dual #(
        .CMD_CLKS_PER_BIT (N_CMD),
        .PIC_CLKS_PER_BIT (N_PIC),
        .STOP_BITS        (SB)
    ) dut (
        .clock_system (clk),
        .rstn         (rstn),
        .mode         (mode),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .pic_valid    (pic_valid),
        .pic_data     (pic_data),
        .pic_ready    (pic_ready),
        .tx           (tx),
        .busy         (busy),
        .tx_done      (tx_done),
        .frame_mode   (frame_mode)
    );

    always #5 clk = ~clk;

    // Frame-level reference: a frame is (offset, bit period, byte, mode)
    logic       m_busy  = 1'b0;
    logic       m_done  = 1'b0;
    logic       m_fmode = 1'b0;
    int         m_off   = 0;
    int         m_n     = N_CMD;
    logic [7:0] m_data  = 8'h00;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_fmode <= 1'b0;
            m_off   <= 0;
        end else if (m_busy) begin
            m_off <= m_off + 1;
            if (m_off + 1 == (9 + SB) * m_n) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (mode ? pic_valid : cmd_valid) begin
                m_busy  <= 1'b1;
                m_off   <= 0;
                m_fmode <= mode;
                m_n     <= mode ? N_PIC : N_CMD;
                m_data  <= mode ? pic_data : cmd_data;
            end
        end
    end

    function automatic logic line_at(input int off, input int n, input logic [7:0] d);
        int slot;
        slot = off / n;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 || rstn === 1'b0) begin
                chk("tx",         tx,         m_busy ? line_at(m_off, m_n, m_data) : 1'b1);
                chk("busy",       busy,       m_busy);
                chk("tx_done",    tx_done,    m_done);
                chk("frame_mode", frame_mode, m_fmode);
                chk("cmd_ready",  cmd_ready,  ~m_busy & ~mode);
                chk("pic_ready",  pic_ready,  ~m_busy & mode);
            end
        end
    end

    // Records tx falling edges (start bits) in negedge-sample units
    int   cyc = 0;
    int   last_fall = 0;
    int   prev_fall = 0;
    logic prev_tx = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_tx === 1'b1 && tx === 1'b0) begin
                prev_fall = last_fall;
                last_fall = cyc;
            end
            prev_tx = tx;
        end
    end

    // Offer a byte on the chosen source; returns at the first sample after accept
    task automatic send(input logic sel, input logic [7:0] d);
        bit got;
        got = 1'b0;
        #1;
        mode = sel;
        if (sel) begin
            pic_valid = 1'b1;
            pic_data  = d;
        end else begin
            cmd_valid = 1'b1;
            cmd_data  = d;
        end
        for (int i = 0; i < 30000 && !got; i++) begin
            @(negedge clk);
            if (sel ? pic_ready : cmd_ready) got = 1'b1;
        end
        if (!got) chk("accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        pic_valid = 1'b0;
        @(negedge clk);
    endtask

    // From frame offset 0, count samples until tx_done (bounded)
    task automatic wait_done(input int limit, output int off);
        bit seen;
        seen = 1'b0;
        off  = 0;
        while (!seen && off < limit) begin
            @(negedge clk);
            off++;
            if (tx_done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 1'b0, 1'b1);
    endtask

    // From frame offset 0, check mid-bit line values and the done pulse
    task automatic pin_frame(input logic [9:0] b, input int n);
        int cur;
        cur = 0;
        for (int s = 0; s < 10; s++) begin
            while (cur < s * n + n / 2) begin
                @(negedge clk);
                cur++;
            end
            chk($sformatf("pin_bit%0d", s), tx, b[s]);
            chk("pin_busy", busy, 1'b1);
        end
        while (cur < (9 + SB) * n - 1) begin
            @(negedge clk);
            cur++;
        end
        chk("pin_done_early", tx_done, 1'b0);
        @(negedge clk);
        chk("pin_done", tx_done, 1'b1);
        chk("pin_idle", busy, 1'b0);
    endtask

    initial begin
        int cur;
        int off;
        bit seen;

        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk("rst_tx",    tx,         1'b1);
        chk("rst_busy",  busy,       1'b0);
        chk("rst_done",  tx_done,    1'b0);
        chk("rst_fmode", frame_mode, 1'b0);
        #29 rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 0x55 at command rate
        send(1'b0, 8'h55);
        pin_frame(10'b10_1010_1010, N_CMD);

        // 0xA3 at picture rate
        send(1'b1, 8'hA3);
        pin_frame(10'b11_0100_0110, N_PIC);

        // Unselected picture source waits until mode selects it
        #1;
        mode      = 1'b0;
        pic_valid = 1'b1;
        pic_data  = 8'h3C;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("unsel_pic_ready", pic_ready, 1'b0);
            chk("unsel_tx", tx, 1'b1);
        end
        @(posedge clk);
        #1 mode = 1'b1;
        @(posedge clk);
        #1 pic_valid = 1'b0;
        @(negedge clk);
        chk("sel_busy", busy, 1'b1);
        chk("sel_fmode", frame_mode, 1'b1);
        wait_done(20000, off);
        chk_int("pic_frame_len", off, (9 + SB) * N_PIC);

        // Mode change mid-frame does not affect the running frame
        send(1'b0, 8'h96);
        cur = 0;
        while (cur < 100) begin
            @(negedge clk);
            cur++;
        end
        #1;
        mode      = 1'b1;
        pic_valid = 1'b1;
        pic_data  = 8'h5A;
        while (cur < 200) begin
            @(negedge clk);
            cur++;
        end
        chk("midframe_fmode", frame_mode, 1'b0);
        seen = 1'b0;
        while (!seen && cur < 1000) begin
            @(negedge clk);
            cur++;
            if (tx_done) seen = 1'b1;
        end
        chk_int("cmd_len_after_toggle", cur, 520);
        @(negedge clk);
        chk("next_busy", busy, 1'b1);
        chk("next_fmode", frame_mode, 1'b1);
        #1 pic_valid = 1'b0;
        wait_done(20000, off);
        chk_int("next_pic_len", off, 12500);
        #1 mode = 1'b0;

        // Back-to-back command bytes with valid held
        cmd_valid = 1'b1;
        cmd_data  = 8'h00;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (cmd_ready) seen = 1'b1;
        end
        @(posedge clk);
        #1 cmd_data = 8'hFF;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (cmd_ready) seen = 1'b1;
        end
        chk("b2b_second_ready", seen, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        wait_done(2000, off);
        chk_int("b2b_start_spacing", last_fall - prev_fall, 521);

        // Asynchronous reset in the middle of a command frame
        send(1'b0, 8'hC3);
        repeat (300) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", tx_done, 1'b0);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;
        send(1'b0, 8'h81);
        pin_frame(10'b11_0000_0010, N_CMD);

        // Random command bytes, random gaps, mode and data churn mid-frame
        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(1'b0, 8'($urandom));
            seen = 1'b0;
            off  = 0;
            while (!seen && off < 700) begin
                @(negedge clk);
                off++;
                if (tx_done) begin
                    seen = 1'b1;
                end else begin
                    #1;
                    if ($urandom_range(0, 7) == 0) mode = ~mode;
                    cmd_data = 8'($urandom);
                end
            end
            chk_int("rand_frame_len", off, (9 + SB) * N_CMD);
            #1 mode = 1'b0;
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
